wb_push_arbiter: RTL and testbench
==================================

Name: wb_push_arbiter

Overview:
- Round-robin arbiter sharing one pipelined Wishbone device port (the FIFO push side) between N_PORTS Wishbone controllers.
- Grant locks to one controller for the full duration of its cyc.
- Tracks outstanding pushes (stb accepted, ack pending) and aborts a wedged cycle after a timeout.
- Sits between producer blocks and the FIFO write port. Single beat per stb, no address.

Parameters:
- N_PORTS, 4, number of upstream controllers (2..8).
- DATA_WIDTH, 8, data width per port; matches FIFO buffer width.
- MAX_OUTSTANDING, 4, max accepted-but-unacked stbs per grant; further stbs stalled.
- TIMEOUT, 64, cycles with outstanding>0 and no ack before abort.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- m_cyc_i  in  N_PORTS  per-controller cyc.
- m_stb_i  in  N_PORTS  per-controller stb.
- m_dat_i  in  N_PORTS*DATA_WIDTH  per-controller data; port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_stall_o  out  N_PORTS  per-controller stall.
- m_ack_o  out  N_PORTS  per-controller ack.
- m_err_o  out  N_PORTS  per-controller err (timeout abort).
- s_cyc_o  out  1  downstream cyc.
- s_stb_o  out  1  downstream stb.
- s_dat_o  out  DATA_WIDTH  downstream data.
- s_stall_i  in  1  downstream stall (FIFO full).
- s_ack_i  in  1  downstream ack.
- grant_o  out  N_PORTS  one-hot current owner; all zero when idle.
- outstanding_o  out  clog2(MAX_OUTSTANDING)+1  pending ack count.

Behaviour:
- Reset (rst_ni low at posedge):
  - State IDLE; grant_o=0; round-robin pointer=0; outstanding=0; timer=0.
  - All registered outputs 0.
  - Reset mid-cycle drops the grant at once; in-flight acks are discarded.
- States: IDLE, GRANTED, ABORT.
- IDLE:
  - s_cyc_o=0, s_stb_o=0. All m_stall_o=1, m_ack_o=0.
  - If any m_cyc_i is high, pick the first requester at or after the pointer (wrapping modulo N_PORTS), register it into grant_o, and go to GRANTED next cycle.
  - The pointer updates to winner+1 (mod N_PORTS).
  - Arbitration latency is one cycle: cyc asserted at t gives grant_o valid and stall low at t+1.
- GRANTED, owner g:
  - Combinational routing: s_cyc_o=m_cyc_i[g]; s_stb_o=m_stb_i[g] && !cap; s_dat_o=m_dat_i[g].
  - m_stall_o[g]=s_stall_i || cap, where cap = (outstanding==MAX_OUTSTANDING).
  - m_ack_o[g]=s_ack_i. All non-owners get stall=1, ack=0, err=0.
- Outstanding counter:
  - +1 on accept (s_stb_o && !s_stall_i), -1 on s_ack_i, unchanged when both occur.
  - Never exceeds MAX_OUTSTANDING. s_ack_i arriving with outstanding==0 is ignored (no underflow).
- Release:
  - m_cyc_i[g] low gives s_cyc_o=0 the same cycle.
  - Next state is IDLE; outstanding and timer clear; pending acks are dropped (Wishbone abort semantics).
  - Minimum one IDLE cycle between grants.
- Timer:
  - Counts while outstanding>0 and !s_ack_i; clears on any ack or when outstanding==0.
  - On reaching TIMEOUT, go to ABORT.
- ABORT, one cycle:
  - m_err_o[g]=1 and s_cyc_o=0; other outputs as IDLE. Outstanding clears.
  - Next state IDLE. The owner must drop cyc; if it holds cyc, it competes normally on the next arbitration.
- Starvation bound: any requester holding cyc is granted within N_PORTS-1 other grants.
- FIFO coupling: the FIFO's ack lags push by one cycle, so outstanding_o never exceeds 1 in normal operation; MAX_OUTSTANDING covers generic devices.

Test Plan:
- Single controller: port 0 cyc+stb for 3 beats (0xA1, 0xA2, 0xA3) with s_stall_i=0 -> grant_o=0001 at t+1; s_stb_o for 3 cycles; three m_ack_o[0] pulses each 1 cycle after accept; outstanding_o peaks at 1; returns to IDLE after cyc drops.
- Round robin: ports 0, 1, 3 hold cyc continuously, each releasing after 2 beats -> grant order 0, 1, 3, 0; one idle cycle between grants; port 2 never granted.
- Backpressure: s_stall_i held high for 5 cycles while port 2 is granted with stb high -> m_stall_o[2]=1 for those 5 cycles; no acks; data 0x5C held and accepted on the first cycle with stall low.
- Abort: port 1 drops cyc with outstanding_o=1 -> s_cyc_o low the same cycle; the late s_ack_i is not routed to m_ack_o[1]; the next grant to port 1 starts with outstanding_o=0.
- Timeout: TIMEOUT=8; device never acks one accepted stb -> after 8 cycles m_err_o[port] pulses for 1 cycle; grant_o returns to 0; outstanding_o=0.
- Reset mid-grant: rst_ni low for 1 cycle while port 3 is granted with outstanding=1 -> next cycle grant_o=0, outstanding_o=0, all acks and errs 0; arbitration restarts from pointer 0.

Source files
------------

// File: rtl/wb_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_push_arbiter
// Brief    : Round-robin arbiter sharing one pipelined Wishbone push port
//            between N_PORTS controllers. The grant is held for the owner's
//            whole cyc, accepted-but-unacked pushes are counted, and a cycle
//            that sees no ack for TIMEOUT cycles is aborted with err.
// Revision : 1.0 - initial release
// ============================================================================
module wb_push_arbiter #(
    parameter int N_PORTS         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [N_PORTS-1:0]                m_cyc_i,
    input  logic [N_PORTS-1:0]                m_stb_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]     m_dat_i,
    output logic [N_PORTS-1:0]                m_stall_o,
    output logic [N_PORTS-1:0]                m_ack_o,
    output logic [N_PORTS-1:0]                m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic                              s_stall_i,
    input  logic                              s_ack_i,
    output logic [N_PORTS-1:0]                grant_o,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o
);

    localparam int c_ptr_w = $clog2(N_PORTS);
    localparam int c_out_w = $clog2(MAX_OUTSTANDING) + 1;
    localparam int c_tmr_w = $clog2(TIMEOUT + 1);
    localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUTSTANDING);
    localparam logic [c_tmr_w-1:0] c_timeout = c_tmr_w'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        ABORT   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_ptr_w-1:0]   ptr_q, ptr_d;
    logic [c_ptr_w-1:0]   owner_q, owner_d;
    logic [c_out_w-1:0]   outstanding_q, outstanding_d;
    logic [c_tmr_w-1:0]   timer_q, timer_d;

    logic                  w_any_req;
    logic [c_ptr_w-1:0]    w_winner;
    int                    w_dist;
    int                    w_best;
    logic                  w_own_cyc;
    logic                  w_own_stb;
    logic [DATA_WIDTH-1:0] w_own_dat;
    logic                  w_cap;
    logic                  w_push;
    logic                  w_accept;
    logic                  w_ack_ok;

    // Round-robin pick: nearest requester at or after the pointer, wrapping.
    always_comb begin
        w_any_req = |m_cyc_i;
        w_winner  = '0;
        w_best    = N_PORTS;
        w_dist    = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_dist = (k - int'(ptr_q) + N_PORTS) % N_PORTS;
            if (m_cyc_i[k] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = c_ptr_w'(k);
            end
        end
    end

    // Select the current owner's cyc, stb and data.
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_dat = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (owner_q == c_ptr_w'(k)) begin
                w_own_cyc = m_cyc_i[k];
                w_own_stb = m_stb_i[k];
                w_own_dat = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state, counters and combinational routing to/from the owner.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        outstanding_d = outstanding_q;
        timer_d       = timer_q;
        s_cyc_o       = 1'b0;
        s_stb_o       = 1'b0;
        s_dat_o       = '0;
        m_stall_o     = '1;
        m_ack_o       = '0;
        m_err_o       = '0;
        grant_o       = '0;
        w_cap         = (outstanding_q == c_max_out);
        w_push        = 1'b0;
        w_accept      = 1'b0;
        w_ack_ok      = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_any_req) begin
                    owner_d       = w_winner;
                    ptr_d         = (w_winner == c_ptr_w'(N_PORTS - 1)) ? '0 : w_winner + 1'b1;
                    state_d       = GRANTED;
                    outstanding_d = '0;
                    timer_d       = '0;
                end
            end

            GRANTED: begin
                // Stb is withheld at the cap so the counter can never overflow.
                w_push   = w_own_cyc && w_own_stb && !w_cap;
                w_accept = w_push && !s_stall_i;
                w_ack_ok = s_ack_i && (outstanding_q != '0);
                s_cyc_o  = w_own_cyc;
                s_stb_o  = w_push;
                s_dat_o  = w_own_dat;
                for (int k = 0; k < N_PORTS; k++) begin
                    if (owner_q == c_ptr_w'(k)) begin
                        grant_o[k]   = 1'b1;
                        m_stall_o[k] = s_stall_i || w_cap;
                        m_ack_o[k]   = w_own_cyc && s_ack_i;
                    end
                end

                if (!w_own_cyc) begin
                    // Owner released: pending acks are abandoned.
                    state_d       = IDLE;
                    outstanding_d = '0;
                    timer_d       = '0;
                end else begin
                    if (w_accept && !w_ack_ok) begin
                        outstanding_d = outstanding_q + 1'b1;
                    end else if (w_ack_ok && !w_accept) begin
                        outstanding_d = outstanding_q - 1'b1;
                    end

                    if ((outstanding_q != '0) && !s_ack_i) begin
                        timer_d = timer_q + 1'b1;
                        if (timer_d == c_timeout) begin
                            state_d       = ABORT;
                            outstanding_d = '0;
                            timer_d       = '0;
                        end
                    end else begin
                        timer_d = '0;
                    end
                end
            end

            ABORT: begin
                for (int k = 0; k < N_PORTS; k++) begin
                    if (owner_q == c_ptr_w'(k)) begin
                        m_err_o[k] = 1'b1;
                    end
                end
                state_d       = IDLE;
                outstanding_d = '0;
                timer_d       = '0;
            end

            default: begin
                state_d       = IDLE;
                outstanding_d = '0;
                timer_d       = '0;
            end
        endcase
    end

    assign outstanding_o = outstanding_q;

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            outstanding_q <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            outstanding_q <= outstanding_d;
            timer_q       <= timer_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_push_arbiter
// Brief    : Self-checking bench for wb_push_arbiter: vector table, directed
//            multi-cycle sequences and a randomized run against a reference
//            model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_push_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MO = 4;
    localparam int TO = 8;
    localparam int OW = 3;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N-1:0]    m_cyc_i, m_stb_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N-1:0]    m_stall_o, m_ack_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_stall_i, s_ack_i;
    logic [DW-1:0]   s_dat_o;
    logic [OW-1:0]   outstanding_o;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    wb_push_arbiter #(
        .N_PORTS(N), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_dat_i(m_dat_i),
        .m_stall_o(m_stall_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_o(s_dat_o),
        .s_stall_i(s_stall_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .outstanding_o(outstanding_o)
    );

    typedef struct packed {
        logic [3:0] cyc;
        logic [3:0] stb;
        logic [7:0] dat;
        logic       stall;
        logic       ack;
        logic [3:0] e_grant;
        logic       e_scyc;
        logic       e_sstb;
        logic [7:0] e_sdat;
        logic [3:0] e_mstall;
        logic [3:0] e_mack;
        logic [2:0] e_out;
    } vec_t;

    typedef enum {M_IDLE, M_OWNED, M_ERR} mphase_t;

    vec_t    vt[$];
    int      order[$];
    int      rr_exp[4] = '{0, 1, 3, 0};
    int      beats[N];
    bit      drop[N];
    bit      acc_prev;
    logic [N-1:0] prev_g;
    logic [N-1:0] prev_cyc;
    int      direct_switch;
    int      p2_grants;
    int      waited[N];

    mphase_t mph;
    int      mown, mptr, mout, msil, w2, wi, mout_old;
    bit      hang, took, full;
    logic [N-1:0]  e_grant, e_stall, e_ack, e_err;
    logic          e_scyc, e_sstb;
    logic [DW-1:0] e_sdat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m_cyc_i   = '0;
        m_stb_i   = '0;
        m_dat_i   = '0;
        s_stall_i = 1'b0;
        s_ack_i   = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        idle_in();
        do_reset();

        // Reset state
        #1;
        chk("rst_grant", 32'(grant_o), 32'(0));
        chk("rst_out",   32'(outstanding_o), 32'(0));
        chk("rst_scyc",  32'(s_cyc_o), 32'(0));
        chk("rst_stall", 32'(m_stall_o), 32'(4'hF));
        chk("rst_ack",   32'(m_ack_o), 32'(0));
        chk("rst_err",   32'(m_err_o), 32'(0));
        tick();

        // Single controller, three beats, ack one cycle after each accept
        vt.push_back('{4'b0001, 4'b0001, 8'hA1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b1111, 4'b0000, 3'd0});
        vt.push_back('{4'b0001, 4'b0001, 8'hA1, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 8'hA1, 4'b1110, 4'b0000, 3'd0});
        vt.push_back('{4'b0001, 4'b0001, 8'hA2, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hA2, 4'b1110, 4'b0001, 3'd1});
        vt.push_back('{4'b0001, 4'b0001, 8'hA3, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hA3, 4'b1110, 4'b0001, 3'd1});
        vt.push_back('{4'b0001, 4'b0000, 8'h00, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b1110, 4'b0001, 3'd1});
        vt.push_back('{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 8'h00, 4'b1110, 4'b0000, 3'd0});
        vt.push_back('{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b1111, 4'b0000, 3'd0});
        // Backpressure on port 2: five stalled cycles, then accepted
        vt.push_back('{4'b0100, 4'b0100, 8'h5C, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b1111, 4'b0000, 3'd0});
        for (int i = 0; i < 5; i++)
            vt.push_back('{4'b0100, 4'b0100, 8'h5C, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h5C, 4'b1111, 4'b0000, 3'd0});
        vt.push_back('{4'b0100, 4'b0100, 8'h5C, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h5C, 4'b1011, 4'b0000, 3'd0});
        vt.push_back('{4'b0100, 4'b0000, 8'h00, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 8'h00, 4'b1011, 4'b0100, 3'd1});
        vt.push_back('{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 8'h00, 4'b1011, 4'b0000, 3'd0});
        vt.push_back('{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b1111, 4'b0000, 3'd0});

        foreach (vt[i]) begin
            m_cyc_i   = vt[i].cyc;
            m_stb_i   = vt[i].stb;
            m_dat_i   = {N{vt[i].dat}};
            s_stall_i = vt[i].stall;
            s_ack_i   = vt[i].ack;
            #1;
            chk($sformatf("vec%0d_grant", i), 32'(grant_o),       32'(vt[i].e_grant));
            chk($sformatf("vec%0d_scyc", i),  32'(s_cyc_o),       32'(vt[i].e_scyc));
            chk($sformatf("vec%0d_sstb", i),  32'(s_stb_o),       32'(vt[i].e_sstb));
            chk($sformatf("vec%0d_stall", i), 32'(m_stall_o),     32'(vt[i].e_mstall));
            chk($sformatf("vec%0d_ack", i),   32'(m_ack_o),       32'(vt[i].e_mack));
            chk($sformatf("vec%0d_out", i),   32'(outstanding_o), 32'(vt[i].e_out));
            chk($sformatf("vec%0d_err", i),   32'(m_err_o),       32'(0));
            if (vt[i].e_sstb) chk($sformatf("vec%0d_sdat", i), 32'(s_dat_o), 32'(vt[i].e_sdat));
            tick();
        end

        // Round robin among ports 0, 1, 3, each releasing after two beats
        do_reset();
        prev_g = '0; acc_prev = 1'b0; direct_switch = 0; p2_grants = 0;
        for (int p = 0; p < N; p++) begin beats[p] = 0; drop[p] = 1'b0; end
        for (int c = 0; c < 24; c++) begin
            for (int p = 0; p < N; p++) begin
                if (p != 2) begin
                    if (drop[p]) begin m_cyc_i[p] = 1'b0; drop[p] = 1'b0; beats[p] = 0; end
                    else m_cyc_i[p] = 1'b1;
                    m_stb_i[p] = m_cyc_i[p];
                end
            end
            s_stall_i = 1'b0;
            s_ack_i   = acc_prev;
            #1;
            acc_prev = s_stb_o && !s_stall_i;
            for (int p = 0; p < N; p++) begin
                if (p != 2 && grant_o[p] && m_stb_i[p] && !m_stall_o[p]) begin
                    beats[p]++;
                    if (beats[p] == 2) drop[p] = 1'b1;
                end
            end
            if (grant_o != '0 && prev_g == '0) order.push_back(oh_idx(grant_o));
            if (grant_o != '0 && prev_g != '0 && grant_o != prev_g) direct_switch++;
            prev_g = grant_o;
            tick();
        end
        chk("rr_count", 32'(order.size() >= 4), 32'(1));
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_order%0d", i), 32'((i < order.size()) ? order[i] : -1), 32'(rr_exp[i]));
        foreach (order[i]) if (order[i] == 2) p2_grants++;
        chk("rr_port2_never", 32'(p2_grants), 32'(0));
        chk("rr_idle_gap", 32'(direct_switch), 32'(0));

        // Abort by release with an ack still pending
        do_reset();
        m_cyc_i = 4'b0010; m_stb_i = 4'b0010; m_dat_i = {N{8'h11}};
        #1; tick();
        #1; chk("abt_grant", 32'(grant_o), 32'(4'b0010)); chk("abt_stb", 32'(s_stb_o), 32'(1)); tick();
        m_stb_i = '0;
        #1; chk("abt_out1", 32'(outstanding_o), 32'(1)); tick();
        m_cyc_i = '0;
        #1; chk("abt_scyc_drop", 32'(s_cyc_o), 32'(0)); tick();
        s_ack_i = 1'b1;
        #1; chk("abt_late_ack", 32'(m_ack_o), 32'(0)); chk("abt_idle", 32'(grant_o), 32'(0)); tick();
        s_ack_i = 1'b0; m_cyc_i = 4'b0010;
        #1; tick();
        #1; chk("abt_regrant", 32'(grant_o), 32'(4'b0010)); chk("abt_out0", 32'(outstanding_o), 32'(0)); tick();
        m_cyc_i = '0;
        #1; tick();
        #1; tick();

        // Timeout: one push never acked
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001; m_dat_i = {N{8'h77}};
        #1; tick();
        #1; chk("to_grant", 32'(grant_o), 32'(4'b0001)); tick();
        m_stb_i = '0;
        for (int c = 0; c < TO; c++) begin
            #1;
            chk($sformatf("to_wait%0d_err", c), 32'(m_err_o), 32'(0));
            chk($sformatf("to_wait%0d_out", c), 32'(outstanding_o), 32'(1));
            tick();
        end
        m_cyc_i = '0;
        #1;
        chk("to_err",   32'(m_err_o), 32'(4'b0001));
        chk("to_scyc",  32'(s_cyc_o), 32'(0));
        chk("to_grant0", 32'(grant_o), 32'(0));
        chk("to_out0",  32'(outstanding_o), 32'(0));
        tick();
        #1; chk("to_err_pulse", 32'(m_err_o), 32'(0)); chk("to_idle", 32'(grant_o), 32'(0)); tick();

        // Reset in the middle of a grant to port 3
        m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
        #1; tick();
        #1; chk("rg_grant", 32'(grant_o), 32'(4'b1000)); tick();
        m_stb_i = '0;
        #1; chk("rg_out1", 32'(outstanding_o), 32'(1));
        rst_ni = 1'b0; tick();
        rst_ni = 1'b1; m_cyc_i = 4'b1010; s_ack_i = 1'b1;
        #1;
        chk("rg_grant0", 32'(grant_o), 32'(0));
        chk("rg_out0",   32'(outstanding_o), 32'(0));
        chk("rg_ack0",   32'(m_ack_o), 32'(0));
        chk("rg_err0",   32'(m_err_o), 32'(0));
        tick();
        s_ack_i = 1'b0;
        #1; chk("rg_ptr0", 32'(grant_o), 32'(4'b0010)); tick();
        idle_in();
        #1; tick();
        #1; tick();

        // Randomized run against the reference model
        do_reset();
        mph = M_IDLE; mown = 0; mptr = 0; mout = 0; msil = 0; hang = 1'b0;
        prev_g = '0; prev_cyc = '0;
        for (int p = 0; p < N; p++) waited[p] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < N; p++) begin
                if (m_cyc_i[p]) begin
                    if ($urandom_range(0, 7) == 0) m_cyc_i[p] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    m_cyc_i[p] = 1'b1;
                end
                m_stb_i[p] = m_cyc_i[p] && ($urandom_range(0, 1) == 1);
                m_dat_i[p*DW +: DW] = 8'($urandom);
            end
            s_stall_i = ($urandom_range(0, 3) == 0);
            s_ack_i   = (mph == M_OWNED) && (mout > 0) && !hang && ($urandom_range(0, 3) != 0);
            #1;

            e_grant = '0; e_stall = '1; e_ack = '0; e_err = '0;
            e_scyc = 1'b0; e_sstb = 1'b0; e_sdat = '0; full = 1'b0;
            if (mph == M_OWNED) begin
                full          = (mout == MO);
                e_grant[mown] = 1'b1;
                e_scyc        = m_cyc_i[mown];
                e_sstb        = m_cyc_i[mown] && m_stb_i[mown] && !full;
                e_sdat        = m_dat_i[mown*DW +: DW];
                e_stall[mown] = s_stall_i || full;
                e_ack[mown]   = m_cyc_i[mown] && s_ack_i;
            end else if (mph == M_ERR) begin
                e_err[mown] = 1'b1;
            end
            chk("rnd_grant", 32'(grant_o), 32'(e_grant));
            chk("rnd_scyc",  32'(s_cyc_o), 32'(e_scyc));
            chk("rnd_sstb",  32'(s_stb_o), 32'(e_sstb));
            chk("rnd_stall", 32'(m_stall_o), 32'(e_stall));
            chk("rnd_ack",   32'(m_ack_o), 32'(e_ack));
            chk("rnd_err",   32'(m_err_o), 32'(e_err));
            chk("rnd_out",   32'(outstanding_o), 32'(mout));
            if (e_sstb) chk("rnd_sdat", 32'(s_dat_o), 32'(e_sdat));

            // Starvation bound, observed on the DUT's own grants
            for (int k = 0; k < N; k++) if (!m_cyc_i[k]) waited[k] = 0;
            if (grant_o != '0 && prev_g == '0) begin
                wi = oh_idx(grant_o);
                chk("rnd_starve", 32'(waited[wi] <= N - 1), 32'(1));
                waited[wi] = 0;
                for (int k = 0; k < N; k++)
                    if (k != wi && prev_cyc[k] && m_cyc_i[k]) waited[k]++;
            end
            prev_g   = grant_o;
            prev_cyc = m_cyc_i;

            // Advance the model by one clock
            case (mph)
                M_IDLE: begin
                    if (m_cyc_i != '0) begin
                        w2 = -1;
                        for (int i = N - 1; i >= 0; i--)
                            if (m_cyc_i[(mptr + i) % N]) w2 = (mptr + i) % N;
                        mown = w2;
                        mptr = (w2 + 1) % N;
                        mph  = M_OWNED;
                        mout = 0;
                        msil = 0;
                        hang = ($urandom_range(0, 9) == 0);
                    end
                end
                M_OWNED: begin
                    if (!m_cyc_i[mown]) begin
                        mph = M_IDLE; mout = 0; msil = 0;
                    end else begin
                        mout_old = mout;
                        took     = e_sstb && !s_stall_i;
                        if (took) mout++;
                        if (s_ack_i && mout_old > 0) mout--;
                        if (mout_old > 0 && !s_ack_i) msil++;
                        else msil = 0;
                        if (msil == TO) begin
                            mph = M_ERR; mout = 0; msil = 0;
                        end
                    end
                end
                default: mph = M_IDLE;
            endcase
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
